// File: rtl/ibus_line_buffer.sv
// Instruction-side IBus-to-CBus bridge with a single-line fetch buffer.
// A miss fetches one aligned line as a CBus burst; hits are answered combinationally.

package ibus_line_buffer_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic mlen_t burst_len(input int beats);
    case (beats)
      1:       return MLEN1;
      2:       return MLEN2;
      4:       return MLEN4;
      8:       return MLEN8;
      default: return MLEN16;
    endcase
  endfunction

endpackage

module ibus_line_buffer
  import ibus_line_buffer_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter bit BYPASS     = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  icreq,
  input  cbus_resp_t icresp,
  input  logic       flush
);

  localparam int    LINE_BYTES = 8 * LINE_BEATS;
  localparam int    OFF_W      = $clog2(LINE_BYTES);
  localparam int    CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int    TAG_W      = 64 - OFF_W;
  localparam mlen_t LINE_LEN   = burst_len(LINE_BEATS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]       state;
  logic [63:0]      line_mem [LINE_BEATS];
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic [CNT_W-1:0] cnt;
  logic             pend_flush;

  logic [63:0]      beat_shift;
  logic [CNT_W-1:0] hit_idx;
  logic [63:0]      hit_beat;
  logic             hit;
  logic             miss;
  logic             burst_done;

  assign beat_shift = ireq.addr >> 3;
  assign hit_idx    = (LINE_BEATS > 1) ? beat_shift[CNT_W-1:0] : '0;
  assign hit_beat   = line_mem[hit_idx];
  assign hit        = !BYPASS && (state == S_IDLE) && ireq.valid && line_valid &&
                      (tag == ireq.addr[63:OFF_W]);
  assign miss       = (state == S_IDLE) && ireq.valid && !hit;
  assign burst_done = (state == S_FETCH) && icresp.ready && icresp.last;

  logic unused_bits;
  assign unused_bits = ^{ireq.addr[1:0], beat_shift[63:CNT_W]};

  // Bypass answers on the final beat itself; buffered mode only answers hits.
  always_comb begin
    iresp = '0;
    if (BYPASS) begin
      if (burst_done) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = icreq.addr[2] ? icresp.data[63:32] : icresp.data[31:0];
      end
    end else if (hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = ireq.addr[2] ? hit_beat[63:32] : hit_beat[31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      line_valid <= 1'b0;
      pend_flush <= 1'b0;
      cnt        <= '0;
      tag        <= '0;
      icreq      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!BYPASS && flush) line_valid <= 1'b0;
          if (miss) begin
            state          <= S_FETCH;
            cnt            <= '0;
            icreq.valid    <= 1'b1;
            icreq.is_write <= 1'b0;
            icreq.strobe   <= '0;
            icreq.data     <= '0;
            if (BYPASS) begin
              icreq.addr <= ireq.addr;
              icreq.size <= MSIZE4;
              icreq.len  <= MLEN1;
            end else begin
              icreq.addr <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
              icreq.size <= MSIZE8;
              icreq.len  <= LINE_LEN;
            end
          end
        end
        default: begin
          // A flush landing mid-burst must still leave the refilled line invalid.
          if (!BYPASS && flush) pend_flush <= 1'b1;
          if (icresp.ready) begin
            cnt <= cnt + 1'b1;
            if (icresp.last) begin
              state      <= S_IDLE;
              icreq      <= '0;
              pend_flush <= 1'b0;
              if (!BYPASS) begin
                line_valid <= !(pend_flush || flush);
                tag        <= icreq.addr[63:OFF_W];
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!BYPASS && (state == S_FETCH) && icresp.ready) line_mem[cnt] <= icresp.data;
  end

endmodule

// File: tb/tb_ibus_line_buffer.sv
// Directed self-checking bench for ibus_line_buffer: one buffered instance (4 beats)
// and one bypass instance, driven and sampled on the falling clock edge.

module tb_ibus_line_buffer;
  import ibus_line_buffer_pkg::*;

  localparam int LB = 4;

  logic       clk;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  icreq;
  cbus_resp_t icresp;
  logic       flush;

  ibus_req_t  b_ireq;
  ibus_resp_t b_iresp;
  cbus_req_t  b_icreq;
  cbus_resp_t b_icresp;
  logic       b_flush;

  int n_checks = 0;
  int n_fail   = 0;

  ibus_line_buffer #(.LINE_BEATS(LB), .BYPASS(1'b0)) dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp),
    .icreq(icreq), .icresp(icresp), .flush(flush)
  );

  ibus_line_buffer #(.LINE_BEATS(1), .BYPASS(1'b1)) dut_bypass (
    .clk(clk), .resetn(resetn), .ireq(b_ireq), .iresp(b_iresp),
    .icreq(b_icreq), .icresp(b_icresp), .flush(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word index times 0x11111111, top nibble tweaked per 256MB region.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] w;
    w = {28'h0, a[5:2]} * 32'h1111_1111;
    w = w ^ {a[31:28] ^ 4'h8, 28'h0};
    return w;
  endfunction

  task automatic fill_line(input logic [63:0] base, input bit gap, input int flush_beat);
    logic [63:0] a;
    for (int k = 0; k < LB; k++) begin
      if (gap && k == 1) begin
        icresp = '0;
        @(negedge clk);
      end
      a = base + 64'(8 * k);
      icresp.ready = 1'b1;
      icresp.last  = (k == LB - 1);
      icresp.data  = {word_at(a + 64'd4), word_at(a)};
      flush = (k == flush_beat);
      #1;
      n_checks++;
      if (icreq.valid !== 1'b1 || icreq.addr !== base || iresp !== '0) begin
        n_fail++;
        $display("[TB] FAIL burst_beat%0d: valid=%b addr=%h iresp=%h, required valid=1 addr=%h iresp=0",
                 k, icreq.valid, icreq.addr, iresp, base);
      end
      @(negedge clk);
    end
    icresp = '0;
    flush  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ireq = '0; icresp = '0; flush = 1'b0;
    b_ireq = '0; b_icresp = '0; b_flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (icreq !== '0 || iresp !== '0 || b_icreq !== '0 || b_iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: icreq=%h iresp=%h b_icreq=%h b_iresp=%h, required all 0",
               icreq, iresp, b_icreq, b_iresp);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [63:0] addrs [4];
    logic [31:0] exp   [4];
    addrs = '{64'h8000_0004, 64'h8000_0008, 64'h8000_001C, 64'h8000_0013};
    exp   = '{32'h1111_1111, 32'h2222_2222, 32'h7777_7777, 32'h4444_4444};
    @(negedge clk);
    ireq = '{valid: 1'b1, addr: 64'h8000_0000};
    #1;
    n_checks++;
    if (iresp !== '0 || icreq.valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cold_miss_cycle: iresp=%h icreq.valid=%b, required 0/0", iresp, icreq.valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.is_write !== 1'b0 || icreq.size !== MSIZE8 ||
        icreq.addr !== 64'h8000_0000 || icreq.strobe !== 8'h0 || icreq.data !== 64'h0 ||
        icreq.len !== MLEN4) begin
      n_fail++;
      $display("[TB] FAIL cold_req_fields: got %h, required valid=1 size=MSIZE8 addr=80000000 len=MLEN4 rest 0",
               icreq);
    end
    fill_line(64'h8000_0000, 1'b0, -1);
    #1;
    n_checks++;
    if (iresp !== '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0} || icreq.valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cold_data_after_last: iresp=%h icreq.valid=%b, required iresp=3_00000000 valid=0",
               iresp, icreq.valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ireq.addr = addrs[i];
      #1;
      n_checks++;
      if (iresp.data_ok !== 1'b1 || iresp.addr_ok !== 1'b1 || iresp.data !== exp[i] ||
          icreq.valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hit_%h: ok=%b%b data=%h icreq.valid=%b, required 11 data=%h valid=0",
                 addrs[i], iresp.addr_ok, iresp.data_ok, iresp.data, icreq.valid, exp[i]);
      end
    end
  endtask

  task automatic test_line_crossing();
    @(negedge clk);
    ireq.addr = 64'h8000_0020;
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL cross_miss: iresp=%h, required 0", iresp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.addr !== 64'h8000_0020 || icreq.len !== MLEN4) begin
      n_fail++;
      $display("[TB] FAIL cross_req: valid=%b addr=%h len=%0d, required 1 80000020 3",
               icreq.valid, icreq.addr, icreq.len);
    end
    fill_line(64'h8000_0020, 1'b1, -1);
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h8888_8888) begin
      n_fail++;
      $display("[TB] FAIL cross_hit20: data_ok=%b data=%h, required 1 88888888", iresp.data_ok, iresp.data);
    end
    @(negedge clk);
    ireq.addr = 64'h8000_003C;
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("[TB] FAIL cross_hit3c: data_ok=%b data=%h, required 1 ffffffff", iresp.data_ok, iresp.data);
    end
    @(negedge clk);
    ireq.addr = 64'h8000_0000;
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL old_line_evicted: iresp=%h, required 0", iresp);
    end
  endtask

  task automatic test_flush_in_fetch();
    @(negedge clk);
    fill_line(64'h8000_0000, 1'b0, 1);
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL flush_fetch_invalid: iresp=%h, required 0", iresp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.addr !== 64'h8000_0000) begin
      n_fail++;
      $display("[TB] FAIL flush_fetch_reissue: valid=%b addr=%h, required 1 80000000", icreq.valid, icreq.addr);
    end
    fill_line(64'h8000_0000, 1'b0, -1);
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL refill_hit: data_ok=%b data=%h, required 1 00000000", iresp.data_ok, iresp.data);
    end
  endtask

  task automatic test_flush_idle_and_addr_change();
    @(negedge clk);
    ireq.addr = 64'h8000_0004;
    flush = 1'b1;
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h1111_1111) begin
      n_fail++;
      $display("[TB] FAIL flush_cycle_hit: data_ok=%b data=%h, required 1 11111111", iresp.data_ok, iresp.data);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL after_flush_miss: iresp=%h, required 0", iresp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.addr !== 64'h8000_0000) begin
      n_fail++;
      $display("[TB] FAIL aligned_req: valid=%b addr=%h, required 1 80000000", icreq.valid, icreq.addr);
    end
    ireq.addr = 64'h9000_0000;
    fill_line(64'h8000_0000, 1'b0, -1);
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL new_addr_miss: iresp=%h, required 0", iresp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.addr !== 64'h9000_0000) begin
      n_fail++;
      $display("[TB] FAIL new_addr_req: valid=%b addr=%h, required 1 90000000", icreq.valid, icreq.addr);
    end
    fill_line(64'h9000_0000, 1'b0, -1);
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h1000_0000) begin
      n_fail++;
      $display("[TB] FAIL hit_90000000: data_ok=%b data=%h, required 1 10000000", iresp.data_ok, iresp.data);
    end
    @(negedge clk);
    ireq.addr = 64'h9000_0004;
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h0111_1111) begin
      n_fail++;
      $display("[TB] FAIL hit_90000004: data_ok=%b data=%h, required 1 01111111", iresp.data_ok, iresp.data);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    ireq.addr = 64'h8000_0000;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      icresp = '{ready: 1'b1, last: 1'b0, data: {word_at(64'h8000_0004 + 64'(8 * k)),
                                                 word_at(64'h8000_0000 + 64'(8 * k))}};
      @(negedge clk);
    end
    icresp = '0;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (icreq !== '0 || iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_burst: icreq=%h iresp=%h, required 0/0", icreq, iresp);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (iresp !== '0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_miss: iresp=%h, required 0", iresp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (icreq.valid !== 1'b1 || icreq.addr !== 64'h8000_0000) begin
      n_fail++;
      $display("[TB] FAIL post_reset_req: valid=%b addr=%h, required 1 80000000", icreq.valid, icreq.addr);
    end
    fill_line(64'h8000_0000, 1'b0, -1);
    #1;
    n_checks++;
    if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_hit: data_ok=%b data=%h, required 1 00000000", iresp.data_ok, iresp.data);
    end
    @(negedge clk);
    ireq = '0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    b_ireq = '{valid: 1'b1, addr: 64'h8000_0004};
    #1;
    n_checks++;
    if (b_iresp !== '0 || b_icreq.valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL byp_idle: iresp=%h valid=%b, required 0/0", b_iresp, b_icreq.valid);
    end
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (b_icreq.valid !== 1'b1 || b_icreq.addr !== 64'h8000_0004 || b_icreq.size !== MSIZE4 ||
          b_icreq.len !== MLEN1 || b_icreq.is_write !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL byp_req%0d: got %h, required valid=1 addr=80000004 MSIZE4 MLEN1", r, b_icreq);
      end
      if (r == 1) begin
        b_icresp = '0;
        #1;
        n_checks++;
        if (b_iresp !== '0) begin
          n_fail++;
          $display("[TB] FAIL byp_wait: iresp=%h, required 0", b_iresp);
        end
        @(negedge clk);
      end
      b_icresp = '{ready: 1'b1, last: 1'b1,
                   data: (r == 0) ? 64'hAAAA_AAAA_BBBB_BBBB : 64'h1234_5678_9ABC_DEF0};
      #1;
      n_checks++;
      if (b_iresp !== '{addr_ok: 1'b1, data_ok: 1'b1, data: (r == 0) ? 32'hAAAA_AAAA : 32'h1234_5678}) begin
        n_fail++;
        $display("[TB] FAIL byp_data%0d: iresp=%h, required ok=11 data=%h", r, b_iresp,
                 (r == 0) ? 32'hAAAA_AAAA : 32'h1234_5678);
      end
      @(negedge clk);
      b_icresp = '0;
      #1;
      n_checks++;
      if (b_icreq.valid !== 1'b0 || b_iresp !== '0) begin
        n_fail++;
        $display("[TB] FAIL byp_return: valid=%b iresp=%h, required 0/0", b_icreq.valid, b_iresp);
      end
      if (r == 1) b_ireq = '0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_line_crossing();
    test_flush_in_fetch();
    test_flush_idle_and_addr_change();
    test_reset_mid_burst();
    test_bypass();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
